// File: rtl/dcache_pkg.sv
// dcache_pkg: FSM state, width helpers and byte merge
// shared by the set-associative data cache.
package dcache_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    MISS_WAIT = 1'b1
  } state_e;

  function automatic int off_w(input int wpl);
    return $clog2(wpl) + 2;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets,
                               input int wpl);
    return 32 - off_w(wpl) - idx_w(sets);
  endfunction

  function automatic int cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic logic [31:0] merge_word(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8]
                          : old_w[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// dcache_victim_sel: invalid-first victim choice
// backed by a per-set round-robin pointer.
module dcache_victim_sel
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2,
  localparam int IW = idx_w(NUM_SETS),
  localparam int WW = way_w(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [IW-1:0]       idx_i,
  input  logic                install_i,
  output logic [WW-1:0]       way_o
);

  logic [WW-1:0] ptr_q [NUM_SETS];
  logic [WW-1:0] nxt;
  logic          found;

  // lowest invalid way wins, else the set's pointer
  always_comb begin
    way_o = ptr_q[idx_i];
    found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        way_o = WW'(w);
        found = 1'b1;
      end
    end
    nxt = (int'(way_o) + 1 >= NUM_WAYS) ? '0
        : way_o + WW'(1);
  end

  // pointer moves past the way just filled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++)
        ptr_q[s] <= '0;
    end else if (install_i) begin
      ptr_q[idx_i] <= nxt;
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way write-through no-allocate D-cache.
// Optional perf counters under DCACHE_PERF_CNT_EN.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int NUM_SETS       = 4,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 4,
  parameter int LAT_GO         = 5,
  parameter int LAT_RET        = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read_en,
  input  logic        cpu_write_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byte_en,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        sb_enq_valid,
  output logic [31:0] sb_enq_addr,
  output logic [31:0] sb_enq_data,
  output logic [3:0]  sb_enq_byte_en,
  input  logic        sb_drain_valid,
  input  logic [31:0] sb_drain_addr,
  input  logic [31:0] sb_drain_data,
  input  logic [3:0]  sb_drain_byte_en,
  output logic        sb_drain_ack,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);

  localparam int OFF      = off_w(WORDS_PER_LINE);
  localparam int IDX      = idx_w(NUM_SETS);
  localparam int TAG_W    = tag_w(NUM_SETS, WORDS_PER_LINE);
  localparam int MISS_LAT = LAT_GO + LAT_RET;
  localparam int CNT_W    = cnt_w(MISS_LAT);
  localparam int WW       = way_w(NUM_WAYS);
  localparam int WOB      = OFF - 2;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         addr_q, wdata_q;
  logic [3:0]          be_q;
  logic                st_q, sh_q;
  logic [31:0]         rf_q [WORDS_PER_LINE];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q [NUM_SETS][NUM_WAYS];
  logic [31:0]         data_q [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];

  logic [IDX-1:0]   c_idx, d_idx, m_idx;
  logic [TAG_W-1:0] c_tag, d_tag, m_tag;
  logic [WOB-1:0]   c_wrd, d_wrd, rf_k;
  logic [WW-1:0]    c_way, d_way, vic_way;
  logic             c_hit, d_hit;
  logic             idle, st_req, ld_miss, st_miss;
  logic             last, rf_act, wr_fin, install;
  logic [31:0]      line_d [WORDS_PER_LINE];

  assign c_idx = cpu_addr[OFF +: IDX];
  assign c_tag = cpu_addr[31 -: TAG_W];
  assign c_wrd = cpu_addr[2 +: WOB];
  assign d_idx = sb_drain_addr[OFF +: IDX];
  assign d_tag = sb_drain_addr[31 -: TAG_W];
  assign d_wrd = sb_drain_addr[2 +: WOB];
  assign m_idx = addr_q[OFF +: IDX];
  assign m_tag = addr_q[31 -: TAG_W];

  assign idle    = (state_q == IDLE);
  assign st_req  = cpu_write_en && !cpu_read_en;
  assign ld_miss = idle && cpu_read_en && !c_hit;
  assign st_miss = idle && st_req && !c_hit;
  assign last    = (int'(cnt_q) == MISS_LAT - 1);
  assign rf_k    = WOB'(int'(cnt_q) - LAT_GO);
  assign rf_act  = !idle && !st_q
                && int'(cnt_q) >= LAT_GO
                && int'(cnt_q) < LAT_GO + WORDS_PER_LINE;
  assign wr_fin  = !idle && st_q && last;
  assign install = !idle && !st_q && last;

  // tag lookup for the cpu port and the drain port
  always_comb begin
    c_hit = 1'b0;
    c_way = '0;
    d_hit = 1'b0;
    d_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[c_idx][w] && tag_q[c_idx][w] == c_tag) begin
        c_hit = 1'b1;
        c_way = WW'(w);
      end
      if (valid_q[d_idx][w] && tag_q[d_idx][w] == d_tag) begin
        d_hit = 1'b1;
        d_way = WW'(w);
      end
    end
  end

  // refill line with the word arriving this cycle folded in
  always_comb begin
    for (int k = 0; k < WORDS_PER_LINE; k++)
      line_d[k] = (rf_act && rf_k == WOB'(k)) ? mem_rdata
                                               : rf_q[k];
  end

  dcache_victim_sel #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_vic (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (valid_q[m_idx]),
    .idx_i     (m_idx),
    .install_i (install),
    .way_o     (vic_way)
  );

  // cpu, store-buffer and memory outputs, all low in reset
  always_comb begin
    cpu_rdata      = '0;
    cpu_stall      = 1'b0;
    sb_enq_valid   = 1'b0;
    sb_enq_addr    = '0;
    sb_enq_data    = '0;
    sb_enq_byte_en = '0;
    sb_drain_ack   = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_byte_en    = '0;
    if (!reset) begin
      if (cpu_read_en && c_hit)
        cpu_rdata = data_q[c_idx][c_way][c_wrd];
      cpu_stall = ld_miss || st_miss || (!idle && !wr_fin);
      sb_enq_valid   = st_req && c_hit && !sh_q;
      sb_enq_addr    = cpu_addr;
      sb_enq_data    = cpu_wdata;
      sb_enq_byte_en = cpu_byte_en;
      sb_drain_ack   = sb_drain_valid && idle;
      unique case (1'b1)
        rf_act: begin
          mem_read_en = 1'b1;
          mem_addr    = {addr_q[31:OFF], rf_k, 2'b00};
          mem_byte_en = 4'hF;
        end
        wr_fin: begin
          mem_write_en = 1'b1;
          mem_addr     = addr_q;
          mem_wdata    = wdata_q;
          mem_byte_en  = be_q;
        end
        sb_drain_ack: begin
          mem_write_en = 1'b1;
          mem_addr     = sb_drain_addr;
          mem_wdata    = sb_drain_data;
          mem_byte_en  = sb_drain_byte_en;
        end
        default: ;
      endcase
    end
  end

  // miss FSM, refill capture and valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      st_q    <= 1'b0;
      sh_q    <= 1'b0;
      for (int k = 0; k < WORDS_PER_LINE; k++)
        rf_q[k] <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        valid_q[s] <= '0;
    end else begin
      sh_q <= st_req && c_hit;
      unique case (state_q)
        IDLE: begin
          if (ld_miss || st_miss) begin
            state_q <= MISS_WAIT;
            cnt_q   <= '0;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            be_q    <= cpu_byte_en;
            st_q    <= st_miss;
          end
        end
        MISS_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (rf_act)
            rf_q[rf_k] <= mem_rdata;
          if (last) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
          if (install)
            valid_q[m_idx][vic_way] <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // line install on refill, byte merge on drain hit
  always_ff @(posedge clk) begin
    if (install) begin
      tag_q[m_idx][vic_way] <= m_tag;
      for (int k = 0; k < WORDS_PER_LINE; k++)
        data_q[m_idx][vic_way][k] <= line_d[k];
    end
    if (sb_drain_ack && d_hit)
      data_q[d_idx][d_way][d_wrd] <= merge_word(
        data_q[d_idx][d_way][d_wrd],
        sb_drain_data, sb_drain_byte_en);
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hits_q, misses_q;

  // free-running hit and miss event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (idle && ((cpu_read_en && c_hit) || sb_enq_valid))
        hits_q <= hits_q + 32'd1;
      if (ld_miss || st_miss)
        misses_q <= misses_q + 32'd1;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed scoreboard bench for
// the set-associative data cache, default parameters.
module tb_dcache_assoc;

  localparam int GO  = 5;
  localparam int MIS = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read_en, cpu_write_en;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_byte_en;
  logic        cpu_stall;
  logic        sb_enq_valid;
  logic [31:0] sb_enq_addr, sb_enq_data;
  logic [3:0]  sb_enq_byte_en;
  logic        sb_drain_valid, sb_drain_ack;
  logic [31:0] sb_drain_addr, sb_drain_data;
  logic [3:0]  sb_drain_byte_en;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byte_en;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  dcache_assoc dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_read_en      (cpu_read_en),
    .cpu_write_en     (cpu_write_en),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_byte_en      (cpu_byte_en),
    .cpu_rdata        (cpu_rdata),
    .cpu_stall        (cpu_stall),
    .sb_enq_valid     (sb_enq_valid),
    .sb_enq_addr      (sb_enq_addr),
    .sb_enq_data      (sb_enq_data),
    .sb_enq_byte_en   (sb_enq_byte_en),
    .sb_drain_valid   (sb_drain_valid),
    .sb_drain_addr    (sb_drain_addr),
    .sb_drain_data    (sb_drain_data),
    .sb_drain_byte_en (sb_drain_byte_en),
    .sb_drain_ack     (sb_drain_ack),
    .mem_read_en      (mem_read_en),
    .mem_write_en     (mem_write_en),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_byte_en      (mem_byte_en),
    .mem_rdata        (mem_rdata)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .perf_hits        (perf_hits),
    .perf_misses      (perf_misses)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // backing memory: unwritten words read {C0DE, addr[15:0]}
  logic [31:0] mem_w [256];
  bit          mem_set [256];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [7:0] i;
    i = a[9:2];
    return mem_set[i] ? mem_w[i] : {16'hC0DE, a[15:0]};
  endfunction

  assign mem_rdata = mem_read_en ? mem_val(mem_addr) : 32'h0;

  always @(posedge clk) begin
    if (!reset && mem_write_en) begin
      logic [31:0] cur;
      cur = mem_val(mem_addr);
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
      mem_w[mem_addr[9:2]]   <= cur;
      mem_set[mem_addr[9:2]] <= 1'b1;
    end
  end

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } mem_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } enq_t;

  mem_exp_t    mem_q [$];
  enq_t        enq_q [$];
  logic [31:0] rd_q  [$];

  // monitor: pop and compare whenever the DUT presents output
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_read_en && !cpu_stall) begin
        if (rd_q.size() == 0) fail("unexpected load completion");
        else chk("load rdata", cpu_rdata, rd_q.pop_front());
      end
      if (mem_read_en || mem_write_en) begin
        if (mem_q.size() == 0) begin
          $display("FAIL unexpected mem cmd: addr %h we %0d", mem_addr, mem_write_en);
          checks++;
          errors++;
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          chk("mem write_en", 32'(mem_write_en), 32'(e.we));
          chk("mem read_en", 32'(mem_read_en), 32'(!e.we));
          chk("mem addr", mem_addr, e.addr);
          chk("mem cycle", 32'(cyc), 32'(e.cyc));
          if (e.we) begin
            chk("mem wdata", mem_wdata, e.data);
            chk("mem byte_en", 32'(mem_byte_en), 32'(e.be));
          end
        end
      end
      if (sb_enq_valid) begin
        if (enq_q.size() == 0) fail("unexpected sb_enq_valid");
        else begin
          enq_t q;
          q = enq_q.pop_front();
          chk("sb_enq addr", sb_enq_addr, q.addr);
          chk("sb_enq data", sb_enq_data, q.data);
          chk("sb_enq byte_en", 32'(sb_enq_byte_en), 32'(q.be));
        end
      end
    end
  end

  // issue one load/store, push expectations, count stalls
  task automatic access(input bit rd,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0]  be,
                        input logic [31:0] exp,
                        input int exp_stall,
                        input int hold);
    int c0, st, done, guard;
    logic [31:0] base;
    c0   = cyc;
    base = {a[31:4], 4'h0};
    if (rd) begin
      rd_q.push_back(exp);
      if (exp_stall > 0)
        for (int k = 0; k < 4; k++)
          mem_q.push_back('{1'b0, base + 32'(4*k), 32'h0, 4'h0, c0 + 1 + GO + k});
    end else if (exp_stall > 0) begin
      mem_q.push_back('{1'b1, a, d, be, c0 + MIS});
    end else begin
      enq_q.push_back('{a, d, be});
    end
    cpu_read_en  = rd;
    cpu_write_en = !rd;
    cpu_addr     = a;
    cpu_wdata    = d;
    cpu_byte_en  = be;
    st = 0;
    done = 0;
    guard = 0;
    while (done < hold && guard < 100) begin
      @(negedge clk);
      guard++;
      if (cpu_stall) st++;
      else done++;
    end
    if (guard >= 100) fail("access timeout");
    chk("stall cycles", 32'(st), 32'(exp_stall));
    @(posedge clk);
    #1;
    cpu_read_en  = 1'b0;
    cpu_write_en = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a,
                    input logic [31:0] exp,
                    input int exp_stall);
    access(1'b1, a, 32'h0, 4'h0, exp, exp_stall, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int c1, held, g;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    cpu_read_en      = 1'b1;
    cpu_write_en     = 1'b0;
    cpu_addr         = 32'h100;
    cpu_wdata        = 32'h0;
    cpu_byte_en      = 4'h0;
    sb_drain_valid   = 1'b1;
    sb_drain_addr    = 32'h104;
    sb_drain_data    = 32'h0;
    sb_drain_byte_en = 4'h1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset cpu_stall", 32'(cpu_stall), 32'h0);
    chk("reset cpu_rdata", cpu_rdata, 32'h0);
    chk("reset mem_read_en", 32'(mem_read_en), 32'h0);
    chk("reset mem_write_en", 32'(mem_write_en), 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset sb_drain_ack", 32'(sb_drain_ack), 32'h0);
    chk("reset sb_enq_addr", sb_enq_addr, 32'h0);
    cpu_read_en    = 1'b0;
    sb_drain_valid = 1'b0;
    reset          = 1'b0;
    @(posedge clk);
    #1;

    // cold miss, then hit in the same line
    ld(32'h100, 32'hC0DE0100, MIS + 1);
    ld(32'h108, 32'hC0DE0108, 0);

    // store hit held three cycles: one enqueue, no stall
    access(1'b0, 32'h104, 32'h11223344, 4'hF, 32'h0, 0, 3);

    // drain while idle: ack plus memory write, cache merged
    c1 = cyc;
    mem_q.push_back('{1'b1, 32'h104, 32'h000000AA, 4'h1, c1});
    sb_drain_valid   = 1'b1;
    sb_drain_addr    = 32'h104;
    sb_drain_data    = 32'h000000AA;
    sb_drain_byte_en = 4'h1;
    @(negedge clk);
    chk("drain ack idle", 32'(sb_drain_ack), 32'h1);
    @(posedge clk);
    #1;
    sb_drain_valid = 1'b0;
    ld(32'h104, 32'hC0DE01AA, 0);

    // drain offered during a load miss is held until idle
    fork
      ld(32'h200, 32'hC0DE0200, MIS + 1);
      begin
        repeat (2) @(posedge clk);
        #1;
        c1 = cyc;
        mem_q.push_back('{1'b1, 32'h104, 32'h000000AA, 4'h1, c1 + 9});
        sb_drain_valid = 1'b1;
        held = 0;
        g = 0;
        while (g < 40) begin
          @(negedge clk);
          g++;
          if (sb_drain_ack) break;
          held++;
        end
        chk("drain held cycles", 32'(held), 32'd9);
        @(posedge clk);
        #1;
        sb_drain_valid = 1'b0;
      end
    join

    // store miss: write-through, no allocation
    access(1'b0, 32'h300, 32'hDEADBEEF, 4'hF, 32'h0, MIS, 1);
    ld(32'h300, 32'hDEADBEEF, MIS + 1);
    ld(32'h200, 32'hC0DE0200, 0);
    ld(32'h104, 32'hC0DE01AA, MIS + 1);

    // round-robin replacement within set 0
    pulse_reset();
    ld(32'h000, 32'hC0DE0000, MIS + 1);
    ld(32'h040, 32'hC0DE0040, MIS + 1);
    ld(32'h080, 32'hC0DE0080, MIS + 1);
    ld(32'h040, 32'hC0DE0040, 0);
    ld(32'h000, 32'hC0DE0000, MIS + 1);
    ld(32'h080, 32'hC0DE0080, 0);
    ld(32'h040, 32'hC0DE0040, MIS + 1);

    // another set
    ld(32'h014, 32'hC0DE0014, MIS + 1);
    ld(32'h018, 32'hC0DE0018, 0);

    // reset in the middle of a refill
    cpu_read_en = 1'b1;
    cpu_addr    = 32'h240;
    @(negedge clk);
    chk("abort miss stall", 32'(cpu_stall), 32'h1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort stall in reset", 32'(cpu_stall), 32'h0);
    chk("abort mem_read in reset", 32'(mem_read_en), 32'h0);
    cpu_read_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    ld(32'h240, 32'hC0DE0240, MIS + 1);

    repeat (3) @(posedge clk);
    chk("mem queue drained", 32'(mem_q.size()), 32'h0);
    chk("rdata queue drained", 32'(rd_q.size()), 32'h0);
    chk("enq queue drained", 32'(enq_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Parametrised N-way set-associative write-through, write-no-allocate data cache for the multi-cycle CPU. Successor to the 4-line direct-mapped D-cache.
- Sits between the memory stage, the store buffer and backing memory. Backing memory uses a fixed go/return latency model.
- New versus the previous generation: configurable sets, ways, line size and latency; round-robin victim selection; an explicit store-buffer drain acknowledge.

Parameters:
- NUM_SETS, 4, number of sets; power of two, >=2.
- NUM_WAYS, 2, associativity; 1, 2 or 4.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, >=2.
- LAT_GO, 5, cycles for a request to reach memory.
- LAT_RET, 5, cycles for the return phase; must be >= WORDS_PER_LINE.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cpu_read_en  in  1  load request
- cpu_write_en  in  1  store request
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, lane-aligned
- cpu_byte_en  in  4  store byte enables
- cpu_rdata  out  32  load data
- cpu_stall  out  1  stall the pipeline
- sb_enq_valid / sb_enq_addr / sb_enq_data / sb_enq_byte_en  out  1/32/32/4  store-hit enqueue to the store buffer
- sb_drain_valid / sb_drain_addr / sb_drain_data / sb_drain_byte_en  in  1/32/32/4  store-buffer head
- sb_drain_ack  out  1  drain accepted this cycle
- mem_read_en / mem_write_en  out  1/1  memory commands
- mem_addr / mem_wdata / mem_byte_en  out  32/32/4  memory address, data, enables
- mem_rdata  in  32  memory read data, valid in the same cycle as mem_read_en

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE) + 2 bits of line offset.
  - IDX = log2(NUM_SETS) bits of index, starting at bit OFF.
  - Tag = remaining upper bits.
- Hit: any way of the indexed set that is valid with a matching tag. At most one way may match.
- Reset (asynchronous):
  - State returns to IDLE, counter to 0, every valid bit clears, every victim pointer clears, any in-flight refill is discarded.
  - All outputs are 0.
- Miss latency: MISS_LAT = LAT_GO + LAT_RET. The counter runs 0..MISS_LAT-1.
- FSM IDLE:
  - Load miss: latch address, tag and index; go to MISS_WAIT.
  - Store miss: latch address, data and byte enables; go to MISS_WAIT.
  - Load hit, store hit or no request: stay in IDLE.
- FSM MISS_WAIT, load:
  - At counter LAT_GO+k (k = 0..WORDS_PER_LINE-1): mem_read_en=1, mem_addr = line base + 4k, capture mem_rdata into refill word k.
  - At counter MISS_LAT-1: install the line into the victim way (valid=1, tag written), then return to IDLE.
- FSM MISS_WAIT, store:
  - At counter MISS_LAT-1: mem_write_en=1 with the latched address, data and enables; return to IDLE.
  - No allocation, and cache contents are unchanged.
- Victim selection:
  - Lowest-index invalid way first; otherwise the per-set round-robin pointer.
  - The pointer becomes (installed way + 1) mod NUM_WAYS on every install.
- cpu_stall:
  - Asserted in IDLE on a load miss or store miss.
  - Asserted throughout MISS_WAIT, except the final cycle of a store miss.
  - Stalled cycles: load miss = MISS_LAT+1, store miss = MISS_LAT.
- cpu_rdata: the hit word when cpu_read_en && hit; otherwise 0.
- Store hit:
  - sb_enq_valid = store && hit && !(store hit in the previous cycle), giving a single pulse per store. sb_enq_* fields mirror the cpu_* inputs.
  - The cache array is not written on a store hit; the update happens at drain.
- Drain:
  - sb_drain_ack = sb_drain_valid && state==IDLE.
  - On ack: mem_write_en=1 with the drain fields. If the drain address hits, merge the byte enables into the hitting way's word on the same clock edge.
  - In MISS_WAIT the ack is 0 and the store buffer holds its head.
- Simultaneous load hit and drain to the same word: the load returns the pre-merge data. Store-buffer forwarding is the store buffer's responsibility.
- mem_ready is not an input of this block; the memory latency is fixed.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- When defined, adds outputs perf_hits and perf_misses, each 32-bit, reset to 0, wrapping.
  - perf_hits: +1 on each IDLE cycle with a load hit, or a store hit with sb_enq_valid.
  - perf_misses: +1 on each IDLE-to-MISS_WAIT transition.
- When undefined, the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, MISS_WAIT);
  - merge_word byte-merge function;
  - derived widths: OFF, IDX, TAG_W, CNT_W.
- Sub-module dcache_victim_sel: per-set round-robin pointers plus invalid-first selection. Inputs are the set's valid vector, the index and the install strobe; output is the way number.

Test Plan (default parameters):
1. Cold load 0x100 -> 11 stalled cycles; mem_read at 0x100/0x104/0x108/0x10C on counters 5..8; cpu_rdata = mem[0x100]. A following load of 0x108 hits with no stall.
2. Loads 0x000, then 0x040, then 0x080 (all set 0) -> way0, way1, then way0 evicted. Load 0x040 then hits; load 0x000 then misses.
3. Store hit 0x104 held for 3 cycles -> sb_enq_valid high for exactly 1 cycle; no stall.
4. Store miss 0x300, data 0xDEADBEEF, byte enables 0xF -> 10 stalled cycles; mem_write on counter 9. A following load of 0x300 misses (no allocation).
5. With line 0x100 resident, drain 0x104, data 0x000000AA, byte enables 0x1, while IDLE -> ack and mem write in the same cycle. A later load of 0x104 returns the old word with byte 0 = 0xAA. The same drain issued during a load miss is held (ack=0) until IDLE.
6. Assert reset at counter 3 of a load miss -> cpu_stall=0 immediately. A load of the same address misses again afterward.
